axi4_read_dma_requester: RTL
============================

// Module: axi4_read_dma_requester
// PURPOSE
//  Upstream feeder of the AXI4 master read channel: accepts one DMA read command (byte address + byte count),
//  splits it into inner read requests of at most MaxChunkBeats beats, limits requests in flight, and forwards
//  returned read data to a downstream stream with an end-of-command last flag and RLAST consistency checking.
// PARAMETERS
//  AddressWidth        32   byte address width
//  DataWidth           32   data beat width; bytes per beat BPB = DataWidth/8, power of two
//  InnerIFLengthWidth  16   width of oARLEN (beats); must hold MaxChunkBeats
//  ByteCountWidth      32   width of iCmdByteCount
//  MaxChunkBeats       256  max beats per inner request; power of two
//  MaxOutstanding      4    max inner requests issued with RLAST not yet returned
// PORTS
//  iClock          in   1                   clock, all logic rising-edge
//  iReset          in   1                   synchronous, active-high reset
//  iCmdAddress     in   AddressWidth        start byte address, BPB-aligned
//  iCmdByteCount   in   ByteCountWidth      transfer size in bytes; low log2(BPB) bits ignored
//  iCmdValid       in   1                   command valid
//  oCmdReady       out  1                   high only in IDLE
//  oARADDR         out  AddressWidth        inner request address
//  oARLEN          out  InnerIFLengthWidth  inner request length in beats (1..MaxChunkBeats, never 0)
//  oARVALID        out  1                   inner request valid
//  iARREADY        in   1                   inner request ready
//  iRDATA          in   DataWidth           inner read data
//  iRLAST          in   1                   last beat of an inner request
//  iRVALID         in   1                   inner read data valid
//  oRREADY         out  1                   = iStreamReady while a command is active, else 0
//  oStreamData     out  DataWidth           = iRDATA (combinational pass-through)
//  oStreamValid    out  1                   = iRVALID while a command is active, else 0
//  oStreamLast     out  1                   high on the final beat of the whole command
//  iStreamReady    in   1                   downstream ready
//  oBusy           out  1                   high in any state except IDLE
//  oDone           out  1                   one-cycle pulse when command completes
//  oLastError      out  1                   sticky RLAST mismatch flag; cleared on next command accept
// BEHAVIOUR
//  Reset: state=IDLE; oARVALID=0, oARADDR=0, oARLEN=0, oDone=0, oLastError=0, oBusy=0, all counters 0.
//   oCmdReady=0 during the reset cycle; 1 from the first cycle after reset is deasserted.
//  Accept = iCmdValid & oCmdReady. Latch addr; TotalBeats = iCmdByteCount >> log2(BPB); clear oLastError.
//  FSM: IDLE -accept, TotalBeats!=0-> ISSUE; IDLE -accept, TotalBeats==0-> DONE (no AR, no data).
//   ISSUE: oARVALID registered, asserted the cycle after entry (accept at N -> oARVALID at N+1).
//    oARLEN = min(RemainingIssueBeats, MaxChunkBeats). oARADDR/oARLEN held stable while oARVALID & !iARREADY.
//    On AR handshake: addr += oARLEN*BPB (wraps mod 2^AddressWidth); remaining -= oARLEN; Outstanding++.
//    No new oARVALID while Outstanding==MaxOutstanding; a pending oARVALID is never withdrawn.
//    remaining==0 after handshake -> DRAIN. Back-to-back requests allowed (next oARVALID cycle after handshake).
//   DRAIN: wait until RxBeats==TotalBeats and Outstanding==0 -> DONE.
//   DONE: oDone=1 for exactly one cycle -> IDLE.
//  Outstanding: +1 on AR handshake, -1 on R handshake with iRLAST; both in same cycle -> unchanged.
//  Data: R handshake = iRVALID & oRREADY; RxBeats++ per handshake. oStreamLast = (RxBeats==TotalBeats-1).
//   Expected chunk end: ((RxBeats+1) mod MaxChunkBeats == 0) or (RxBeats+1 == TotalBeats).
//   iRLAST != expected chunk end on any handshake -> oLastError=1 (sticky); data still forwarded.
//  Data accepted in ISSUE and DRAIN (before all requests are issued). Data beats in IDLE/DONE are not accepted.
//  Arithmetic: RxBeats and remaining use ByteCountWidth bits; chunk size fits InnerIFLengthWidth by parameter rule.
//  Reset mid-operation: immediately IDLE, all state discarded. The read channel shares iReset and is cleared together.
// TESTING
//  T1 zero length: addr 0x1000, count 0 -> no oARVALID; oDone pulses 2 cycles after accept; oBusy 1 cycle.
//  T2 single chunk: addr 0x2000, count 64 (DW32) -> one AR addr 0x2000 len 16; 16 beats, oStreamLast on 16th; oDone.
//  T3 split: MaxChunk 256, count 2056 B (514 beats) -> AR lens 256,256,2 at 0x0,0x400,0x800; oStreamLast on beat 514.
//  T4 throttle: MaxOutstanding 4, 6 chunks, iARREADY=1, no R data -> exactly 4 ARs; 5th after first RLAST returns.
//  T5 backpressure/RLAST: iStreamReady toggles 50%, iARREADY held 0 for 5 cycles -> ARADDR/LEN stable, no beat lost;
//   inject RLAST on beat 10 of a 16-beat chunk -> oLastError=1, stays set until next accept clears it.
//  T6 reset in DRAIN with 3 beats pending -> next cycle oBusy=0, oCmdReady=1, oARVALID=0; new command runs clean.

Source files
------------

// File: rtl/axi4_read_dma_requester.sv
// axi4_read_dma_requester: splits one DMA read command into bounded AXI4
// read bursts, throttles bursts in flight and forwards read data downstream.
module axi4_read_dma_requester #(
  parameter int AddressWidth       = 32,
  parameter int DataWidth          = 32,
  parameter int InnerIFLengthWidth = 16,
  parameter int ByteCountWidth     = 32,
  parameter int MaxChunkBeats      = 256,
  parameter int MaxOutstanding     = 4
) (
  input  logic                          iClock,
  input  logic                          iReset,
  input  logic [AddressWidth-1:0]       iCmdAddress,
  input  logic [ByteCountWidth-1:0]     iCmdByteCount,
  input  logic                          iCmdValid,
  output logic                          oCmdReady,
  output logic [AddressWidth-1:0]       oARADDR,
  output logic [InnerIFLengthWidth-1:0] oARLEN,
  output logic                          oARVALID,
  input  logic                          iARREADY,
  input  logic [DataWidth-1:0]          iRDATA,
  input  logic                          iRLAST,
  input  logic                          iRVALID,
  output logic                          oRREADY,
  output logic [DataWidth-1:0]          oStreamData,
  output logic                          oStreamValid,
  output logic                          oStreamLast,
  input  logic                          iStreamReady,
  output logic                          oBusy,
  output logic                          oDone,
  output logic                          oLastError
);

  localparam int BpbLog = $clog2(DataWidth / 8);
  localparam int OutW   = $clog2(MaxOutstanding + 1);
  localparam int BcW    = ByteCountWidth;
  localparam int IlW    = InnerIFLengthWidth;

  localparam logic [BcW-1:0] MaxChunk  = BcW'(MaxChunkBeats);
  localparam logic [BcW-1:0] ChunkMask = MaxChunk - BcW'(1);
  localparam logic [OutW-1:0] MaxOut   = OutW'(MaxOutstanding);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_next;

  logic [BcW-1:0]  total;
  logic [BcW-1:0]  remaining;
  logic [BcW-1:0]  rx;
  logic [BcW-1:0]  rx_inc;
  logic [BcW-1:0]  rem_next;
  logic [BcW-1:0]  cmd_beats;
  logic [OutW-1:0] outstanding;
  logic [OutW-1:0] out_next;
  logic            active;
  logic            accept;
  logic            ar_hs;
  logic            r_hs;
  logic            r_end;
  logic            exp_end;

  function automatic logic [IlW-1:0] chunk_len(input logic [BcW-1:0] beats);
    return (beats >= MaxChunk) ? IlW'(MaxChunk) : IlW'(beats);
  endfunction

  assign active       = (state == ISSUE) || (state == DRAIN);
  assign oCmdReady    = (state == IDLE) && !iReset;
  assign oBusy        = (state != IDLE);
  assign oRREADY      = iStreamReady && active;
  assign oStreamData  = iRDATA;
  assign oStreamValid = iRVALID && active;
  assign oStreamLast  = active && (rx == total - BcW'(1));

  assign accept    = iCmdValid && oCmdReady;
  assign cmd_beats = iCmdByteCount >> BpbLog;
  assign ar_hs     = oARVALID && iARREADY;
  assign r_hs      = iRVALID && oRREADY;
  // A stray RLAST with nothing in flight must not wrap the counter.
  assign r_end     = r_hs && iRLAST && (outstanding != '0);
  assign rx_inc    = rx + BcW'(1);
  assign exp_end   = ((rx_inc & ChunkMask) == '0) || (rx_inc == total);
  assign rem_next  = ar_hs ? remaining - BcW'(oARLEN) : remaining;
  assign out_next  = outstanding + OutW'(ar_hs) - OutW'(r_end);

  always_ff @(posedge iClock) begin
    if (iReset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) state_next = (cmd_beats == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        if (ar_hs && (rem_next == '0)) state_next = DRAIN;
      end
      DRAIN: begin
        if ((rx == total) && (outstanding == '0)) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      oARADDR     <= '0;
      oARLEN      <= '0;
      oARVALID    <= 1'b0;
      oDone       <= 1'b0;
      oLastError  <= 1'b0;
      total       <= '0;
      remaining   <= '0;
      rx          <= '0;
      outstanding <= '0;
    end else begin
      oDone <= (state == DONE);
      if (accept) begin
        oARADDR     <= iCmdAddress;
        oARLEN      <= chunk_len(cmd_beats);
        oARVALID    <= (cmd_beats != '0);
        oLastError  <= 1'b0;
        total       <= cmd_beats;
        remaining   <= cmd_beats;
        rx          <= '0;
        outstanding <= '0;
      end else begin
        if (r_hs) begin
          rx <= rx_inc;
          if (iRLAST != exp_end) oLastError <= 1'b1;
        end
        outstanding <= out_next;
        remaining   <= rem_next;
        if (ar_hs) begin
          oARADDR <= oARADDR + (AddressWidth'(oARLEN) << BpbLog);
        end
        // A pending request is held; a new one needs budget left.
        if (oARVALID && !iARREADY) begin
          oARVALID <= 1'b1;
        end else if ((state == ISSUE) && (rem_next != '0) &&
                     (out_next < MaxOut)) begin
          oARVALID <= 1'b1;
          oARLEN   <= chunk_len(rem_next);
        end else begin
          oARVALID <= 1'b0;
        end
      end
    end
  end

endmodule
